// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for data_memory_hs: access-size encodings, FSM state
// enum and a size-normalisation helper.
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Access size encodings on the size port; 2'b11 is folded onto SZ_WORD.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Capture a canonical size so downstream logic only sees three codes.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// -----------------------------------------------------------------------------
// data_memory_hs_if
// Request/response bundle for data_memory_hs.
//   master : drives req, we, addr, size, sign_ext, w_data; sees r_data, ready,
//            busy, err
//   slave  : the memory side (mirror of master)
// -----------------------------------------------------------------------------
interface data_memory_hs_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [1:0]        size;
  logic              sign_ext;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, size, sign_ext, w_data,
    input  r_data, ready, busy, err
  );

  modport slave (
    input  req, we, addr, size, sign_ext, w_data,
    output r_data, ready, busy, err
  );
endinterface

// File: rtl/dmem_lane_ram.sv
// -----------------------------------------------------------------------------
// dmem_lane_ram
// DEPTH x DATA_W storage split into byte lanes with per-lane write enables and
// a registered read port. The array itself is never reset; only the read
// register is, so the memory output reads zero straight out of reset.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, be     : write strobe and per-lane byte enables
//   idx        : word index shared by read and write
//   wdata      : lane-aligned write data
//   re         : read strobe; q loads the pre-write contents of idx
//   q          : registered read data
// -----------------------------------------------------------------------------
module dmem_lane_ram #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int NUM_LANES = DATA_W / 8,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [NUM_LANES-1:0]              be,
  input  logic [IDX_W-1:0]                  idx,
  input  logic [NUM_LANES-1:0][7:0]         wdata,
  input  logic                              re,
  output logic [NUM_LANES-1:0][7:0]         q
);

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be[l]) mem[idx][l] <= wdata[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (re) q <= mem[idx];
  end

endmodule

// File: rtl/data_memory_hs.sv
// -----------------------------------------------------------------------------
// data_memory_hs
// Byte-addressable data memory behind a req/ready handshake with fixed wait
// states. Each access: accept edge -> WAIT for WAIT_CYCLES edges -> one RESP
// cycle with ready=1 -> IDLE. Loads return the addressed byte/half/word
// right-justified and sign- or zero-extended.
//   clk, rst_n : clock, async active-low reset
//   bus        : data_memory_hs_if.slave (req/we/addr/size/sign_ext/w_data in,
//                r_data/ready/busy/err out)
// Build option: DMEM_ALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses complete with err=1, r_data=0 and no write; when undefined the
// misaligned low address bits are cleared and err stays 0.
// -----------------------------------------------------------------------------
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  data_memory_hs_if.slave bus
);

  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(WAIT_CYCLES + 1);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;

  // Request captured at the accept edge; inputs are ignored afterwards.
  logic              c_we, c_sext;
  logic [1:0]        c_size;
  logic [OFF_W-1:0]  c_off;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_wdata;

  // Response formatting context, latched on completion so r_data stays stable
  // while the next request is in flight.
  logic [1:0]        r_size;
  logic              r_sext;
  logic [OFF_W-1:0]  r_off;

  logic accept, done;
  logic is_byte, is_half, acc_err;
  logic [OFF_W-1:0]  eff_off;
  logic [NUM_LANES-1:0] be;
  logic [DATA_W-1:0] wd_rep;
  logic [DATA_W-1:0] q, q_sh, fmt;

  logic unused_addr;
  assign unused_addr = ^bus.addr[31:IDX_W+OFF_W];

  assign accept = (state == S_IDLE) && bus.req;
  assign done   = (state == S_WAIT) && (cnt == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.req) state_nx = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Loaded with WAIT_CYCLES-1 so the WAIT->RESP edge lands WAIT_CYCLES
  // edges after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (accept)              cnt <= CNT_W'(WAIT_CYCLES - 1);
    else if (state == S_WAIT && cnt != '0) cnt <= cnt - 1'b1;
  end

  // ---------------------------------------------------------------- capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_we    <= 1'b0;
      c_sext  <= 1'b0;
      c_size  <= SZ_BYTE;
      c_off   <= '0;
      c_idx   <= '0;
      c_wdata <= '0;
    end else if (accept) begin
      c_we    <= bus.we;
      c_sext  <= bus.sign_ext;
      c_size  <= norm_size(bus.size);
      c_off   <= bus.addr[OFF_W-1:0];
      c_idx   <= bus.addr[IDX_W+OFF_W-1:OFF_W];
      c_wdata <= bus.w_data;
    end
  end

  assign is_byte = (c_size == SZ_BYTE);
  assign is_half = (c_size == SZ_HALF);

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (is_half && c_off[0]) || (!is_byte && !is_half && (c_off != '0));
  assign eff_off = c_off;
`else
  assign acc_err = 1'b0;
  assign eff_off = is_byte ? c_off :
                   is_half ? (c_off & ~OFF_W'(1)) : '0;
`endif

  // ---------------------------------------------------------------- write path
  // Store data is replicated across lanes; byte enables pick the target lanes.
  always_comb begin
    be     = '1;
    wd_rep = c_wdata;
    if (is_byte) begin
      be     = NUM_LANES'(1) << eff_off;
      wd_rep = {NUM_LANES{c_wdata[7:0]}};
    end else if (is_half) begin
      be     = NUM_LANES'(3) << eff_off;
      wd_rep = {(NUM_LANES/2){c_wdata[15:0]}};
    end
  end

  dmem_lane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (done && c_we && !acc_err),
    .be    (be),
    .idx   (c_idx),
    .wdata (wd_rep),
    .re    (done),
    .q     (q)
  );

  // ---------------------------------------------------------------- response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size <= SZ_BYTE;
      r_sext <= 1'b0;
      r_off  <= '0;
    end else if (done) begin
      r_size <= c_size;
      r_sext <= c_sext;
      r_off  <= eff_off;
    end
  end

  // Right-justify the addressed lanes, then extend. q resets to zero, so the
  // formatted value is zero straight out of reset regardless of context.
  assign q_sh = q >> {r_off, 3'b000};

  always_comb begin
    fmt = q;
    if (r_size == SZ_BYTE)
      fmt = {{(DATA_W-8){r_sext & q_sh[7]}}, q_sh[7:0]};
    else if (r_size == SZ_HALF)
      fmt = {{(DATA_W-16){r_sext & q_sh[15]}}, q_sh[15:0]};
  end

  assign bus.ready = (state == S_RESP);
  assign bus.busy  = (state != S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_err <= 1'b0;
    else if (done) r_err <= acc_err;
  end
  assign bus.r_data = r_err ? '0 : fmt;
  assign bus.err    = bus.ready && r_err;
`else
  assign bus.r_data = fmt;
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_hs.sv
// -----------------------------------------------------------------------------
// tb_data_memory_hs
// Directed table of vectors, a reset-abort sequence and random traffic checked
// against a byte-array model of the memory.
// -----------------------------------------------------------------------------
module tb_data_memory_hs;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;
  localparam int NBYTES      = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_memory_hs_if #(.DATA_W(DATA_W)) bus ();

  data_memory_hs #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mb [NBYTES];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour: byte-addressed, little-endian, wrapping modulo the
  // memory size.
  task automatic model_access(input logic w, input logic [31:0] addr, input logic [1:0] sz,
                              input logic sx, input logic [31:0] wd,
                              output logic [31:0] r, output logic e);
    int n, a;
    logic [31:0] v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a = int'(addr % NBYTES);
    r = '0;
    e = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % n != 0) begin
      e = 1'b1;
      return;
    end
`else
    a = a - (a % n);
`endif
    if (w) begin
      for (int i = 0; i < n; i++) mb[a+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      r = v;
    end
  endtask

  // One handshake. Inputs are scrambled and req re-raised while busy to show
  // that neither affects the access in flight.
  task automatic access(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd, input logic chk_r,
                        input logic [31:0] exp_r, input logic exp_e, input string nm);
    int lat;
    int k;
    logic [31:0] held;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.size = sz;
    bus.sign_ext = sx; bus.w_data = wd;
    @(posedge clk);
    lat = 0;
    k = 0;
    while (lat == 0 && k < WAIT_CYCLES + 5) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({nm, " busy_wait"}, 32'(bus.busy), 32'd1);
        bus.req = 1'b1; bus.we = 1'($urandom); bus.addr = $urandom;
        bus.size = 2'($urandom); bus.sign_ext = 1'($urandom); bus.w_data = $urandom;
      end
      if (bus.ready) lat = k;
    end
    bus.req = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    if (lat != 0) begin
      check({nm, " busy_resp"}, 32'(bus.busy), 32'd1);
      check({nm, " err"}, 32'(bus.err), 32'(exp_e));
      if (chk_r) check({nm, " r_data"}, bus.r_data, exp_r);
      held = bus.r_data;
      @(negedge clk);
      check({nm, " idle_ready"}, {30'd0, bus.ready, bus.busy}, 32'd0);
      check({nm, " idle_err"}, 32'(bus.err), 32'd0);
      check({nm, " r_data_hold"}, bus.r_data, held);
    end
  endtask

  initial begin
    logic [31:0] er, wd, ad;
    logic ee, w, sx;
    logic [1:0] sz;

    rst_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.size = '0;
    bus.sign_ext = 1'b0; bus.w_data = '0;
    repeat (2) @(negedge clk);
    check("reset ready/busy", {30'd0, bus.ready, bus.busy}, 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset r_data", bus.r_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill every word so later random loads never see uninitialised storage.
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      model_access(1'b1, 32'(i * 4), 2'b10, 1'b0, wd, er, ee);
      access(1'b1, 32'(i * 4), 2'b10, 1'b0, wd, 1'b0, 32'd0, 1'b0, "fill");
    end

    //           we    addr        sz     sx    wdata          chk   exp_r          exp_e
    tbl.push_back('{1'b1, 32'h10,  2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h13,  2'b00, 1'b1, 32'h0,        1'b1, 32'hFFFFFFDE,  1'b0});
    tbl.push_back('{1'b0, 32'h10,  2'b01, 1'b0, 32'h0,        1'b1, 32'h0000BEEF,  1'b0});
    tbl.push_back('{1'b1, 32'h11,  2'b00, 1'b0, 32'h0000005A, 1'b0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        1'b1, 32'hDEAD5AEF,  1'b0});
    tbl.push_back('{1'b0, 32'h11,  2'b00, 1'b1, 32'h0,        1'b1, 32'h0000005A,  1'b0});
    tbl.push_back('{1'b0, 32'h12,  2'b01, 1'b1, 32'h0,        1'b1, 32'hFFFFDEAD,  1'b0});
    tbl.push_back('{1'b0, 32'h10,  2'b00, 1'b0, 32'h0,        1'b1, 32'h000000EF,  1'b0});
    tbl.push_back('{1'b0, 32'h10,  2'b11, 1'b1, 32'h0,        1'b1, 32'hDEAD5AEF,  1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
    tbl.push_back('{1'b1, 32'h11,  2'b01, 1'b0, 32'h00007777, 1'b1, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        1'b1, 32'hDEAD5AEF,  1'b0});
    tbl.push_back('{1'b0, 32'h12,  2'b10, 1'b0, 32'h0,        1'b1, 32'h0,         1'b1});
`else
    tbl.push_back('{1'b1, 32'h11,  2'b01, 1'b0, 32'h00007777, 1'b0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        1'b1, 32'hDEAD7777,  1'b0});
    tbl.push_back('{1'b0, 32'h12,  2'b10, 1'b0, 32'h0,        1'b1, 32'hDEAD7777,  1'b0});
`endif
    tbl.push_back('{1'b1, 32'h400, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h000, 2'b10, 1'b0, 32'h0,        1'b1, 32'hCAFEF00D,  1'b0});
    tbl.push_back('{1'b0, 32'h403, 2'b00, 1'b1, 32'h0,        1'b1, 32'hFFFFFFCA,  1'b0});

    foreach (tbl[i]) begin
      model_access(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sext, tbl[i].wdata, er, ee);
      access(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sext, tbl[i].wdata,
             tbl[i].chk, tbl[i].exp_r, tbl[i].exp_e, $sformatf("vec%0d", i));
    end

    // Reset in WAIT aborts a pending store.
    model_access(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, er, ee);
    access(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h0, 1'b0, "pre_abort");
    access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, 32'h11223344, 1'b0, "pre_abort_ld");
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.size = 2'b10;
    bus.w_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort ready/busy", {30'd0, bus.ready, bus.busy}, 32'd0);
    check("abort err", 32'(bus.err), 32'd0);
    check("abort r_data", bus.r_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, 32'h11223344, 1'b0, "post_abort");

    // Random traffic; full 32-bit addresses exercise the wrap.
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      ad = $urandom;
      if (i % 2 == 0) ad = ad & 32'h0000_00FF;
      sz = 2'($urandom);
      sx = 1'($urandom);
      wd = $urandom;
      model_access(w, ad, sz, sx, wd, er, ee);
      access(w, ad, sz, sx, wd, (!w) || ee, er, ee, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_hs.md
DATA_MEMORY_HS -- requirements
Module: data_memory_hs

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits; SHALL be a multiple of 16.
REQ-002 Parameter DEPTH, 256, number of words; SHALL be a power of two.
REQ-003 Parameter WAIT_CYCLES, 2, access wait states; SHALL be >= 1.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req  in  1  access request, sampled only in IDLE.
REQ-007 we  in  1  1 = store, 0 = load.
REQ-008 addr  in  32  byte address; little-endian lane order.
REQ-009 size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-010 sign_ext  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-011 w_data  in  DATA_W  store data, taken from the low-order bits.
REQ-012 r_data  out  DATA_W  load result, valid while ready=1.
REQ-013 ready  out  1  one-cycle completion pulse.
REQ-014 busy  out  1  high in WAIT and RESP.
REQ-015 err  out  1  misalignment flag, valid while ready=1.

Function
REQ-016 FSM states IDLE, WAIT and RESP; IDLE with req=1 -> WAIT at accept edge n; WAIT -> RESP at edge n+WAIT_CYCLES; RESP -> IDLE on the next edge.
REQ-017 addr, we, size, sign_ext and w_data SHALL be captured at the accept edge; later input changes have no effect.
REQ-018 req while busy=1 SHALL be ignored and not queued.
REQ-019 Memory read/write SHALL occur at the WAIT->RESP edge; ready=1 and r_data registered for exactly the RESP cycle.
REQ-020 Outside RESP: ready=0, err=0, r_data holds its last value.
REQ-021 Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH words.
REQ-022 Stores write only the addressed lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all lanes); other lanes unchanged.
REQ-023 Loads return the addressed byte or half right-justified, extended per sign_ext; word loads ignore sign_ext.
REQ-024 A load issued immediately after a store completes SHALL return the updated contents.
REQ-025 Throughput: one access per WAIT_CYCLES+2 cycles.

Reset
REQ-026 rst_n=0 SHALL force IDLE, ready=0, busy=0, err=0 and r_data=0 immediately.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset during WAIT SHALL abort the access; a pending store is discarded and memory stays unchanged.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 completes with the normal timing, err=1, r_data=0 and no memory write.
REQ-030 Macro DMEM_ALIGN_CHECK_EN undefined: misaligned low address bits are forced to zero, the access proceeds normally, and err is tied to 0.

Structure
REQ-031 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 Sub-module dmem_lane_ram SHALL implement the DEPTH x DATA_W array with per-byte write enables and registered read.

Verification
REQ-033 WAIT_CYCLES=2, store word 0xDEADBEEF to 0x10 accepted at edge 0 -> ready=1 only in the cycle after edge 2; busy=1 during cycles after edges 0-2.
REQ-034 Then load byte 0x13 with sign_ext=1 -> r_data 0xFFFFFFDE; load half 0x10 with sign_ext=0 -> r_data 0x0000BEEF.
REQ-035 Store byte 0x5A to 0x11, then load word 0x10 -> r_data 0xDEAD5AEF.
REQ-036 With DMEM_ALIGN_CHECK_EN: store half to 0x11 -> err=1, ready=1, r_data 0; a following word load of 0x10 returns 0xDEAD5AEF.
REQ-037 Drive rst_n low during WAIT of a store of 0x12345678 to 0x20 -> outputs reset at once; a later load of 0x20 returns the prior contents.
REQ-038 DEPTH=256: store word 0xCAFEF00D to 0x400, then load word 0x000 -> r_data 0xCAFEF00D (wrap-around).
